pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. Each cycle it drives the enable (1 = latch) and zero (1 = clear to bubble) inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four hazard sources:
- load-use stalls;
- taken-branch flushes;
- multi-cycle MULT/DIV occupancy of EX;
- syscall halt/resume.

It sits beside the datapath and is the sole driver of every pipeline-register control pin.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/load_use_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller:
// controller state and stage indices for the control-pin vectors.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    HALT    = 2'd2
  } pipe_state_e;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load in EX.
// Register 0 is hardwired, so a load to it never creates a hazard.
module load_use_detect #(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     ex_ld,
  input  logic [REG_ADDR_BITS-1:0] ex_write,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  output logic                     hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs && (id_rs == ex_write);
  assign rt_hit = id_use_rt && (id_rt == ex_write);

  assign hazard = ex_ld
               && (ex_write != '0)
               && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Optional perf counters: define PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int MD_LATENCY    = 8,
  parameter int CNT_BITS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic                     ex_ld,
  input  logic [REG_ADDR_BITS-1:0] ex_write,
  input  logic                     ex_branch_taken,
  input  logic                     ex_md_start,
  input  logic                     mem_syscall_halt,
  input  logic                     resume,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     id_ex_en,
  output logic                     ex_mem_en,
  output logic                     mem_wb_en,
  output logic                     if_id_zero,
  output logic                     id_ex_zero,
  output logic                     ex_mem_zero,
  output logic                     mem_wb_zero,
  output logic                     halted,
  output logic                     md_busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_BITS-1:0]      stall_cycles,
  output logic [CNT_BITS-1:0]      flush_count
`endif
);

  localparam int MD_W =
    (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  if (MD_LATENCY < 2 || CNT_BITS < 1) begin : g_bad_cfg
    $error("pipeline_ctrl: MD_LATENCY >= 2, CNT_BITS >= 1");
  end

  pipe_state_e           state_q;
  pipe_state_e           state_d;
  logic [MD_W-1:0]       md_cnt_q;
  logic [MD_W-1:0]       md_cnt_d;
  logic                  lu_hazard;
  logic                  flush;
  logic [STG_MEM_WB:STG_PC]    en;
  logic [STG_MEM_WB:STG_IF_ID] zero;

  load_use_detect #(
    .REG_ADDR_BITS(REG_ADDR_BITS)
  ) u_lu (
    .ex_ld    (ex_ld),
    .ex_write (ex_write),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .hazard   (lu_hazard)
  );

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    en       = '1;
    zero     = '0;
    flush    = 1'b0;
    if (rst) begin
      en       = '0;
      zero     = '1;
      state_d  = RUN;
      md_cnt_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          // Strict priority; lower rules are dropped this cycle.
          if (mem_syscall_halt) begin
            en[STG_PC]         = 1'b0;
            en[STG_IF_ID]      = 1'b0;
            en[STG_ID_EX]      = 1'b0;
            en[STG_EX_MEM]     = 1'b0;
            zero[STG_MEM_WB]   = 1'b1;
            state_d            = HALT;
          end else if (ex_md_start) begin
            en[STG_PC]         = 1'b0;
            en[STG_IF_ID]      = 1'b0;
            en[STG_ID_EX]      = 1'b0;
            zero[STG_EX_MEM]   = 1'b1;
            md_cnt_d           = MD_W'(MD_LATENCY - 2);
            state_d            = MD_BUSY;
          end else if (ex_branch_taken) begin
            zero[STG_IF_ID]    = 1'b1;
            zero[STG_ID_EX]    = 1'b1;
            flush              = 1'b1;
          end else if (lu_hazard) begin
            en[STG_PC]         = 1'b0;
            en[STG_IF_ID]      = 1'b0;
            zero[STG_ID_EX]    = 1'b1;
          end
        end
        MD_BUSY: begin
          // md_cnt==0 is the release cycle: plain RUN outputs.
          if (md_cnt_q != '0) begin
            en[STG_PC]         = 1'b0;
            en[STG_IF_ID]      = 1'b0;
            en[STG_ID_EX]      = 1'b0;
            zero[STG_EX_MEM]   = 1'b1;
            md_cnt_d           = md_cnt_q - MD_W'(1);
          end else begin
            state_d            = RUN;
          end
        end
        HALT: begin
          if (resume) begin
            state_d            = RUN;
          end else begin
            en[STG_PC]         = 1'b0;
            en[STG_IF_ID]      = 1'b0;
            en[STG_ID_EX]      = 1'b0;
            en[STG_EX_MEM]     = 1'b0;
            zero[STG_MEM_WB]   = 1'b1;
          end
        end
        default: begin
          state_d  = RUN;
          md_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign pc_en       = en[STG_PC];
  assign if_id_en    = en[STG_IF_ID];
  assign id_ex_en    = en[STG_ID_EX];
  assign ex_mem_en   = en[STG_EX_MEM];
  assign mem_wb_en   = en[STG_MEM_WB];
  assign if_id_zero  = zero[STG_IF_ID];
  assign id_ex_zero  = zero[STG_ID_EX];
  assign ex_mem_zero = zero[STG_EX_MEM];
  assign mem_wb_zero = zero[STG_MEM_WB];

  assign halted  = !rst && (state_q == HALT);
  assign md_busy = !rst && (state_q == MD_BUSY);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_BITS-1:0] stall_q;
  logic [CNT_BITS-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en[STG_PC]) stall_q <= stall_q + CNT_BITS'(1);
      if (flush)       flush_q <= flush_q + CNT_BITS'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl (MD_LATENCY=8, CNT_BITS=4).
// Counter checks are active only when PIPE_PERF_CNT_EN is defined.
module tb_pipeline_ctrl;

  localparam int AW = 5;

  // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb zero}
  localparam logic [8:0] C_RUN = 9'b11111_0000;
  localparam logic [8:0] C_RST = 9'b00000_1111;
  localparam logic [8:0] C_HLT = 9'b00001_0001;
  localparam logic [8:0] C_MD  = 9'b00011_0010;
  localparam logic [8:0] C_BR  = 9'b11111_1100;
  localparam logic [8:0] C_LU  = 9'b00111_0100;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_write;
  logic          id_use_rs, id_use_rt, ex_ld;
  logic          ex_branch_taken, ex_md_start;
  logic          mem_syscall_halt, resume;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero;
  logic          halted, md_busy;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0]    stall_cycles, flush_count;
`endif
  logic [8:0]    ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_ADDR_BITS(AW),
    .MD_LATENCY   (8),
    .CNT_BITS     (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_ld           (ex_ld),
    .ex_write        (ex_write),
    .ex_branch_taken (ex_branch_taken),
    .ex_md_start     (ex_md_start),
    .mem_syscall_halt(mem_syscall_halt),
    .resume          (resume),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_zero      (if_id_zero),
    .id_ex_zero      (id_ex_zero),
    .ex_mem_zero     (ex_mem_zero),
    .mem_wb_zero     (mem_wb_zero),
    .halted          (halted),
    .md_busy         (md_busy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs = '0; id_rt = '0; ex_write = '0;
    id_use_rs = 0; id_use_rt = 0; ex_ld = 0;
    ex_branch_taken = 0; ex_md_start = 0;
    mem_syscall_halt = 0; resume = 0;
  endtask

  task automatic lu_rs5;
    ex_ld = 1; ex_write = 5; id_rs = 5; id_use_rs = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    lu_rs5();
    #2;
    check("rst_ctrl", ctrl, C_RST);
    check("rst_halted", halted, 0);
    check("rst_md_busy", md_busy, 0);
    tick();
    rst = 0;
    idle();
    #1;
    check("run_default", ctrl, C_RUN);

    // load-use via rs, one bubble then release
    tick(); lu_rs5(); #1;
    check("lu_rs", ctrl, C_LU);
    tick(); idle(); #1;
    check("lu_after", ctrl, C_RUN);
    // load-use via rt
    tick(); ex_ld = 1; ex_write = 7; id_rt = 7; id_use_rt = 1; #1;
    check("lu_rt", ctrl, C_LU);
    // match but operand not used
    tick(); idle(); ex_ld = 1; ex_write = 7; id_rt = 7; #1;
    check("lu_unused", ctrl, C_RUN);
    // r0 destination never stalls
    tick(); idle(); lu_rs5(); ex_write = 0; id_rs = 0; #1;
    check("lu_r0", ctrl, C_RUN);
    // branch beats load-use
    tick(); idle(); lu_rs5(); ex_branch_taken = 1; #1;
    check("br_lu", ctrl, C_BR);

    // MULT/DIV held high: 7 stall cycles then release
    tick(); idle(); ex_md_start = 1; #1;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("md_ctrl%0d", i), ctrl, C_MD);
      check($sformatf("md_busy%0d", i), md_busy, (i > 0));
      tick();
      if (i == 2) ex_branch_taken = 1;
      if (i == 3) mem_syscall_halt = 1;
      #1;
    end
    check("md_release", ctrl, C_RUN);
    check("md_rel_busy", md_busy, 1);
    tick(); idle(); #1;
    check("md_done", ctrl, C_RUN);
    check("md_done_busy", md_busy, 0);

    // syscall halt, branch ignored, resume at cycle 5
    tick(); mem_syscall_halt = 1; #1;
    check("halt_c0", ctrl, C_HLT);
    check("halt_c0_h", halted, 0);
    for (int c = 1; c < 5; c++) begin
      tick(); ex_branch_taken = 1; #1;
      check($sformatf("halt_c%0d", c), ctrl, C_HLT);
      check($sformatf("halt_c%0d_h", c), halted, 1);
    end
    tick(); resume = 1; #1;
    check("resume", ctrl, C_RUN);
    check("resume_h", halted, 1);
    tick(); idle(); #1;
    check("post_resume", ctrl, C_RUN);
    check("post_resume_h", halted, 0);

`ifdef PIPE_PERF_CNT_EN
    // stalls: 2 load-use + 7 md + 5 halt = 14
    check("stall_14", stall_cycles, 14);
    check("flush_1", flush_count, 1);
    tick(); lu_rs5(); #1;
    tick(); idle(); lu_rs5(); id_rs = 6; ex_write = 6; #1;
    tick(); idle(); #1;
    check("stall_wrap", stall_cycles, 0);
`endif

    // reset during MD_BUSY at md_cnt=3
    tick(); ex_md_start = 1; #1;
    tick(); idle(); #1;
    tick(); tick(); tick();
    check("md_cnt3_ctrl", ctrl, C_MD);
    rst = 1; #1;
    check("mid_rst_ctrl", ctrl, C_RST);
    check("mid_rst_busy", md_busy, 0);
    tick(); rst = 0; #1;
    check("after_rst", ctrl, C_RUN);
    check("after_rst_busy", md_busy, 0);
`ifdef PIPE_PERF_CNT_EN
    check("after_rst_stall", stall_cycles, 0);
    check("after_rst_flush", flush_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
